// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch lookup is combinational; execute-stage resolution updates the table and flags mispredicts.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam int unsigned TGT_W = 30;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [TGT_W-1:0]   tgt_q [ENTRIES];
  logic [TGT_W-1:0]   tgt_d [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [31:0]        cnt_q, cnt_d;

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             upd;
  logic             dir_wrong;
  logic             tgt_wrong;

  // Fetch lookup: reads the pre-update table, so same-index updates are not bypassed
  always_comb begin
    if_idx      = if_pc[IDX_W+1:2];
    if_tag      = if_pc[31:IDX_W+2];
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? {tgt_q[if_idx], 2'b00} : if_pc + 32'd4;
  end

  // Resolution check against what fetch predicted for this instruction
  always_comb begin
    upd         = ex_valid && ex_is_branch;
    dir_wrong   = (ex_pred_taken != ex_branch_taken);
    tgt_wrong   = ex_branch_taken && (ex_pred_target != ex_target);
    mispredict  = upd && (dir_wrong || tgt_wrong);
    redirect_pc = ex_branch_taken ? ex_target : ex_pc + 32'd4;
  end

  // Next table state: train on a hit, allocate only on a taken miss
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    ex_idx  = ex_pc[IDX_W+1:2];
    ex_tag  = ex_pc[31:IDX_W+2];
    ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    if (upd) begin
      if (ex_hit) begin
        if (ex_branch_taken) begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == CTR_ST) ? CTR_ST : ctr_q[ex_idx] + 2'd1;
          tgt_d[ex_idx] = ex_target[31:2];
        end else begin
          ctr_d[ex_idx] = (ctr_q[ex_idx] == CTR_SNT) ? CTR_SNT : ctr_q[ex_idx] - 2'd1;
        end
      end else if (ex_branch_taken) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = ex_target[31:2];
        ctr_d[ex_idx]   = CTR_WT;
      end
    end
  end

  always_comb begin
    cnt_d = mispredict ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_WNT;
      end
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mispredict_cnt = cnt_q;

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Fetch-stage lookup supplies the next-PC guess. Execute-stage update consumes `branch_taken` from `branch_comp` together with the resolved target. The block detects mispredictions, drives the pipeline redirect PC, and keeps a mispredict performance counter.

## Interface
Parameters:
- `ENTRIES`, 16, number of BTB entries; power of two, 2..256.
- `IDX_W`, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `if_pc` input 32: fetch PC to look up.
- `pred_taken` output 1: fetch prediction, branch taken.
- `pred_target` output 32: predicted next PC.
- `ex_valid` input 1: execute stage holds a valid, non-flushed instruction.
- `ex_is_branch` input 1: execute instruction is a conditional branch.
- `ex_pc` input 32: PC of the execute instruction.
- `ex_branch_taken` input 1: resolved direction, from `branch_comp.branch_taken`.
- `ex_target` input 32: resolved taken target (pc + imm).
- `ex_pred_taken` input 1: prediction made for this instruction, piped from fetch.
- `ex_pred_target` input 32: predicted target, piped from fetch.
- `mispredict` output 1: flush and redirect required this cycle.
- `redirect_pc` output 32: correct next PC when `mispredict` is high.
- `mispredict_cnt` output 32: count of mispredicts since reset.

## Operation
- Address split: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry contents: `valid`, `tag`, 30-bit target (target[31:2]; low bits always 00), 2-bit counter.
- Lookup (combinational from `if_pc`):
  - hit = valid[idx] && tag[idx]==tag(if_pc).
  - `pred_taken` = hit && ctr[idx][1].
  - `pred_target` = {target[idx],2'b00} when `pred_taken`, else if_pc+4 (mod 2^32).
- Update enable: upd = ex_valid && ex_is_branch. When upd is low, no state changes.
- Update on a hit at ex index (tag match):
  - taken: ctr saturating increment (11 stays 11); target rewritten with ex_target.
  - not taken: ctr saturating decrement (00 stays 00); target unchanged.
- Update on a miss:
  - taken: allocate or replace. valid=1, tag=tag(ex_pc), target=ex_target, ctr=2'b10.
  - not taken: no allocation.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Mispredict (combinational):
  - `mispredict` = upd && (ex_pred_taken != ex_branch_taken || (ex_branch_taken && ex_pred_target != ex_target)).
  - `redirect_pc` = ex_branch_taken ? ex_target : ex_pc+4.
  - `redirect_pc` is don't-care, but still driven by the formula above, when `mispredict` is low.
- Non-branch instructions (ex_is_branch=0) never mispredict here. Jumps are handled elsewhere.
- `mispredict_cnt` increments by 1 on each cycle `mispredict` is high. It wraps from 0xFFFFFFFF to 0.

## Timing
- Lookup latency is 0 cycles: pred_* follow if_pc in the same cycle.
- Update takes effect at the rising edge ending the upd cycle. It is visible to lookups from the next cycle.
- Simultaneous lookup and update at the same index: the lookup returns the pre-update entry. There is no write-to-read bypass.
- `mispredict` and `redirect_pc` are valid in the same cycle as the ex_* inputs. The pipeline flushes on the following edge.
- Reset values:
  - all valid=0; ctr=01; tags and targets cleared to 0.
  - `mispredict_cnt`=0.
  - Outputs during and right after reset: pred_taken=0, pred_target=if_pc+4, mispredict per inputs.
- Reset asserted mid-update: reset wins. The table is cleared and no counter increment occurs that edge.
- Aliasing: two PCs with the same index and different tags replace each other only on a taken miss.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; mispredict_cnt=0.
- Taken miss update, ex_pc=0x100, target 0x80, pred_taken=0 → mispredict=1, redirect_pc=0x80, cnt=1. Next cycle if_pc=0x100 → pred_taken=1, pred_target=0x80.
- Counter saturation on ex_pc=0x100: three taken updates reach 11, then two not-taken updates → ctr 01, pred_taken=0. A further not-taken gives 00; one taken gives 01, still predicting NT.
- Target change: entry 0x100→0x80 at ctr=11; resolve taken to 0x200 with ex_pred_target=0x80 → mispredict=1, redirect_pc=0x200. Entry target becomes 0x200.
- Alias, ENTRIES=16: entry at 0x100 exists; taken update ex_pc=0x140 (same index 0) → lookup 0x100 misses (pred_target=0x104), 0x140 hits. A not-taken miss at 0x180 leaves 0x140's entry intact.
- Same-cycle hazard and gating:
  - Update and lookup on the same index in one cycle → lookup shows the old entry.
  - ex_valid=0 with mismatching predictions → mispredict=0, no table or cnt change.
  - Assert rst during an update → table cleared, cnt=0.
